// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared ROM widths, ROM depth and loader state encoding.
package rom_loader_pkg;
    localparam int ROM_DEPTH  = 4096;
    localparam int ROMDataBus = 32;
    localparam int ROMAddrBus = 32;
    localparam int WORDS_W    = $clog2(ROM_DEPTH) + 1;
    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, CKSUM, DONE, ERR} state_t;
endpackage

// File: rtl/rom_loader_if.sv
// rom_loader_if: byte stream, ROM write port and core-control signals of the loader.
interface rom_loader_if;
    logic                                  i_start;
    logic                                  i_byte_valid;
    logic [7:0]                            i_byte;
    logic                                  o_byte_ready;
    logic                                  o_rom_we;
    logic [rom_loader_pkg::ROMAddrBus-1:0] o_rom_w_addr;
    logic [rom_loader_pkg::ROMDataBus-1:0] o_rom_w_data;
    logic                                  o_cpu_hold;
    logic                                  o_done;
    logic                                  o_err;
    logic [rom_loader_pkg::WORDS_W-1:0]    o_words;
    modport slave (
        input  i_start, i_byte_valid, i_byte,
        output o_byte_ready, o_rom_we, o_rom_w_addr, o_rom_w_data,
               o_cpu_hold, o_done, o_err, o_words
    );
    modport master (
        output i_start, i_byte_valid, i_byte,
        input  o_byte_ready, o_rom_we, o_rom_w_addr, o_rom_w_data,
               o_cpu_hold, o_done, o_err, o_words
    );
endinterface

// File: rtl/rom_loader_word_asm.sv
// rom_loader_word_asm: little-endian byte-to-word assembler; o_word is complete when o_word_valid.
module rom_loader_word_asm
    import rom_loader_pkg::*;
(
    input  logic                  i_Clk,
    input  logic                  i_reset_n,
    input  logic                  i_clear,
    input  logic                  i_en,
    input  logic [7:0]            i_byte,
    output logic [ROMDataBus-1:0] o_word,
    output logic                  o_word_valid
);
    logic [ROMDataBus-9:0] sr;
    logic [1:0]            lane;
    // The fourth byte bypasses the register so the word is usable in its accept cycle.
    assign o_word       = {i_byte, sr};
    assign o_word_valid = i_en && lane == 2'd3;
    always_ff @(posedge i_Clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sr   <= '0;
            lane <= '0;
        end else if (i_clear) begin
            lane <= '0;
        end else if (i_en) begin
            sr   <= {i_byte, sr[ROMDataBus-9:8]};
            lane <= lane + 2'd1;
        end
    end
endmodule

// File: rtl/rom_loader.sv
// rom_loader: boot-time ROM image loader; holds the core until the image is written.
// Define ROM_LOADER_CKSUM_EN to require a trailing 32-bit sum of all written words.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned           ROM_WORDS      = ROM_DEPTH,
    parameter logic [ROMAddrBus-1:0] BASE_ADDR      = '0,
    parameter int unsigned           TIMEOUT_CYCLES = 1000000,
    parameter bit                    HOLD_AT_RESET  = 1'b1
) (
    input logic         i_Clk,
    input logic         i_reset_n,
    rom_loader_if.slave bus
);
    state_t                state;
    logic [ROMDataBus-1:0] n_words, word;
    logic [31:0]           idle_cnt;
    logic [WORDS_W-1:0]    words_inc;
    logic                  word_valid, accept, restart, loading, timed_out, last_word;
`ifdef ROM_LOADER_CKSUM_EN
    logic [ROMDataBus-1:0] sum;
`endif
    assign accept    = bus.i_byte_valid && bus.o_byte_ready;
    assign restart   = bus.i_start && (state == IDLE || state == DONE || state == ERR);
    assign loading   = state == HDR || state == DATA || state == CKSUM;
    assign timed_out = TIMEOUT_CYCLES != 0 && loading && !accept && idle_cnt == TIMEOUT_CYCLES - 1;
    assign words_inc = bus.o_words + 1'b1;
    assign last_word = ROMDataBus'(words_inc) == n_words;
    rom_loader_word_asm asm_i (
        .i_Clk        (i_Clk),
        .i_reset_n    (i_reset_n),
        .i_clear      (restart),
        .i_en         (accept),
        .i_byte       (bus.i_byte),
        .o_word       (word),
        .o_word_valid (word_valid)
    );
    always_ff @(posedge i_Clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state            <= IDLE;
            n_words          <= '0;
            idle_cnt         <= '0;
            bus.o_byte_ready <= 1'b0;
            bus.o_rom_we     <= 1'b0;
            bus.o_rom_w_addr <= BASE_ADDR;
            bus.o_rom_w_data <= '0;
            bus.o_cpu_hold   <= HOLD_AT_RESET;
            bus.o_done       <= 1'b0;
            bus.o_err        <= 1'b0;
            bus.o_words      <= '0;
`ifdef ROM_LOADER_CKSUM_EN
            sum              <= '0;
`endif
        end else begin
            bus.o_rom_we <= 1'b0;
            // WRITE is not a waiting state, so the idle count only runs while bytes are expected.
            idle_cnt     <= (accept || !loading) ? '0 : idle_cnt + 1'b1;
            if (restart) begin
                state            <= HDR;
                bus.o_byte_ready <= 1'b1;
                bus.o_cpu_hold   <= 1'b1;
                bus.o_done       <= 1'b0;
                bus.o_err        <= 1'b0;
                bus.o_words      <= '0;
                bus.o_rom_w_addr <= BASE_ADDR;
`ifdef ROM_LOADER_CKSUM_EN
                sum              <= '0;
`endif
            end else if (timed_out) begin
                state            <= ERR;
                bus.o_byte_ready <= 1'b0;
                bus.o_err        <= 1'b1;
                bus.o_cpu_hold   <= 1'b1;
            end else begin
                case (state)
                    HDR: if (word_valid) begin
                        n_words <= word;
                        if (word == 0) begin
`ifdef ROM_LOADER_CKSUM_EN
                            state            <= CKSUM;
`else
                            state            <= DONE;
                            bus.o_byte_ready <= 1'b0;
                            bus.o_done       <= 1'b1;
                            bus.o_cpu_hold   <= 1'b0;
`endif
                        end else if (word > ROM_WORDS) begin
                            state            <= ERR;
                            bus.o_byte_ready <= 1'b0;
                            bus.o_err        <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: if (word_valid) begin
                        state            <= WRITE;
                        bus.o_byte_ready <= 1'b0;
                        bus.o_rom_we     <= 1'b1;
                        bus.o_rom_w_data <= word;
                    end
                    WRITE: begin
                        bus.o_words      <= words_inc;
                        bus.o_rom_w_addr <= bus.o_rom_w_addr + 32'd4;
`ifdef ROM_LOADER_CKSUM_EN
                        sum              <= sum + bus.o_rom_w_data;
                        state            <= last_word ? CKSUM : DATA;
                        bus.o_byte_ready <= 1'b1;
`else
                        state            <= last_word ? DONE : DATA;
                        bus.o_byte_ready <= !last_word;
                        bus.o_done       <= last_word;
                        bus.o_cpu_hold   <= !last_word;
`endif
                    end
`ifdef ROM_LOADER_CKSUM_EN
                    CKSUM: if (word_valid) begin
                        state            <= word == sum ? DONE : ERR;
                        bus.o_byte_ready <= 1'b0;
                        bus.o_done       <= word == sum;
                        bus.o_err        <= word != sum;
                        bus.o_cpu_hold   <= word != sum;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized image loads checked against an image-level reference model.
module tb_rom_loader;
    localparam int TO = 16;
    logic i_Clk = 1'b0;
    logic i_reset_n = 1'b0;
    int n_chk = 0;
    int n_err = 0;
    int we_cnt = 0;
    logic [31:0] img[$];
    rom_loader_if bus();
    rom_loader #(.TIMEOUT_CYCLES(TO)) dut (.i_Clk(i_Clk), .i_reset_n(i_reset_n), .bus(bus));
    always #5 i_Clk = ~i_Clk;
    always @(posedge i_Clk) if (bus.o_rom_we) we_cnt <= we_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge i_Clk);
        bus.i_byte_valid = 1'b1;
        bus.i_byte = b;
        for (int i = 0; i < 64 && !bus.o_byte_ready; i++) @(negedge i_Clk);
        if (!bus.o_byte_ready) begin
            check("byte_accept", 32'(bus.o_byte_ready), 32'd1);
            bus.i_byte_valid = 1'b0;
            return;
        end
        @(posedge i_Clk);
        @(negedge i_Clk);
        bus.i_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap < 0 ? int'($urandom_range(3, 0)) : gap);
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        @(negedge i_Clk);
        bus.i_start = 1'b0;
    endtask

    // Model: a header N in 1..4096 yields N writes to consecutive words from 0; the load
    // succeeds iff N <= 4096 (and, with the checksum option, the trailer equals the sum).
    task automatic run_load(input logic [31:0] n, input int gap, input bit bad_ck, input bit poke);
        int base, nw;
        bit ok;
        logic [31:0] sum;
        sum = 0;
        base = we_cnt;
        pulse_start();
        check("hdr_ready", 32'(bus.o_byte_ready), 32'd1);
        check("hdr_hold", 32'(bus.o_cpu_hold), 32'd1);
        check("hdr_flags", 32'({bus.o_done, bus.o_err}), 32'd0);
        check("hdr_words", 32'(bus.o_words), 32'd0);
        send_word(n, gap);
        nw = (n <= 32'd4096) ? int'(n) : 0;
        ok = n <= 32'd4096;
        for (int i = 0; i < nw; i++) begin
            send_word(img[i], gap);
            sum += img[i];
            check("we", 32'(bus.o_rom_we), 32'd1);
            check("addr", bus.o_rom_w_addr, 32'(4 * i));
            check("data", bus.o_rom_w_data, img[i]);
            if (poke && i == 0) begin
                @(negedge i_Clk);
                pulse_start();
            end
        end
        if (nw > 0) @(negedge i_Clk);
`ifdef ROM_LOADER_CKSUM_EN
        if (ok) begin
            send_word(bad_ck ? sum + 32'd1 : sum, gap);
            ok = !bad_ck;
        end
`endif
        check("done", 32'(bus.o_done), 32'(ok));
        check("err", 32'(bus.o_err), 32'(!ok));
        check("hold", 32'(bus.o_cpu_hold), 32'(!ok));
        check("ready_end", 32'(bus.o_byte_ready), 32'd0);
        check("words", 32'(bus.o_words), 32'(nw));
        check("writes", 32'(we_cnt - base), 32'(nw));
        check("end_addr", bus.o_rom_w_addr, 32'(4 * nw));
    endtask

    task automatic fill(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        logic [31:0] n;
        bus.i_start = 1'b0;
        bus.i_byte_valid = 1'b0;
        bus.i_byte = 8'h00;
        #23;
        check("rst_hold", 32'(bus.o_cpu_hold), 32'd1);
        check("rst_ready", 32'(bus.o_byte_ready), 32'd0);
        check("rst_flags", 32'({bus.o_done, bus.o_err, bus.o_rom_we}), 32'd0);
        check("rst_addr", bus.o_rom_w_addr, 32'd0);
        check("rst_data", bus.o_rom_w_data, 32'd0);
        check("rst_words", 32'(bus.o_words), 32'd0);
        @(negedge i_Clk);
        i_reset_n = 1'b1;
        repeat (3) @(negedge i_Clk);
        check("idle_hold", 32'(bus.o_cpu_hold), 32'd1);
        check("idle_ready", 32'(bus.o_byte_ready), 32'd0);

        img = '{32'h0000_0013, 32'h0010_0093};
        run_load(32'd2, 0, 1'b0, 1'b0);
        base = we_cnt;
        bus.i_byte_valid = 1'b1;
        bus.i_byte = 8'h55;
        repeat (4) @(negedge i_Clk);
        check("done_ready", 32'(bus.o_byte_ready), 32'd0);
        check("done_extra", 32'(we_cnt - base), 32'd0);
        check("done_words", 32'(bus.o_words), 32'd2);
        bus.i_byte_valid = 1'b0;
        run_load(32'd2, 0, 1'b1, 1'b0);

        run_load(32'd0, 0, 1'b0, 1'b0);
        run_load(32'd4097, 0, 1'b0, 1'b0);
        run_load(32'hFFFF_FFFF, -1, 1'b0, 1'b0);
        run_load(32'd2, -1, 1'b0, 1'b1);

        fill(3);
        base = we_cnt;
        pulse_start();
        send_word(32'd3, 0);
        send_byte(img[0][7:0], 0);
        send_byte(img[0][15:8], 0);
        repeat (TO - 1) @(negedge i_Clk);
        check("to_early", 32'(bus.o_err), 32'd0);
        @(negedge i_Clk);
        check("to_err", 32'(bus.o_err), 32'd1);
        check("to_hold", 32'(bus.o_cpu_hold), 32'd1);
        check("to_ready", 32'(bus.o_byte_ready), 32'd0);
        check("to_writes", 32'(we_cnt - base), 32'd0);
        run_load(32'd3, TO - 1, 1'b0, 1'b0);

        fill(3);
        pulse_start();
        send_word(32'd3, 0);
        send_word(img[0], 0);
        send_byte(img[1][7:0], 1);
        #3 i_reset_n = 1'b0;
        #1;
        check("mid_rst_flags", 32'({bus.o_done, bus.o_err, bus.o_rom_we, bus.o_byte_ready}), 32'd0);
        check("mid_rst_addr", bus.o_rom_w_addr, 32'd0);
        check("mid_rst_data", bus.o_rom_w_data, 32'd0);
        check("mid_rst_words", 32'(bus.o_words), 32'd0);
        check("mid_rst_hold", 32'(bus.o_cpu_hold), 32'd1);
        @(negedge i_Clk);
        i_reset_n = 1'b1;
        fill(3);
        run_load(32'd3, -1, 1'b0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(5, 0))
                0: n = 32'd0;
                1: n = 32'd4097 + $urandom_range(200, 0);
                2: n = $urandom | 32'h8000_0000;
                default: n = $urandom_range(24, 1);
            endcase
            fill(n <= 32'd4096 ? int'(n) : 0);
            run_load(n, -1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        fill(4096);
        run_load(32'd4096, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Boot-time loader for the 4096x32 instruction ROM.
- Accepts a byte stream from a UART/debug receiver, assembles little-endian 32-bit words and drives the ROM write port.
- Holds the CPU core stalled until the image is fully written, then releases it.
- Sits between the debug receiver and the ROM write port; the ROM read path is untouched.

Parameters:
- ROM_WORDS, 4096: ROM depth in words; the upper bound for the image length.
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; must be a multiple of 4.
- TIMEOUT_CYCLES, 1000000: maximum idle cycles between accepted bytes while loading; 0 disables the timeout.
- HOLD_AT_RESET, 1: if 1, o_cpu_hold is asserted out of reset; if 0, it is deasserted out of reset.

Ports:
- i_Clk  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE and ERR.
- i_byte_valid  in  1  stream byte is valid.
- i_byte  in  8  stream byte.
- o_byte_ready  out  1  loader accepts i_byte this cycle.
- o_rom_we  out  1  ROM write enable; pulses one cycle per word.
- o_rom_w_addr  out  32  ROM byte address, word-aligned.
- o_rom_w_data  out  32  ROM write data.
- o_cpu_hold  out  1  stall/reset request to the core.
- o_done  out  1  level; the load completed successfully.
- o_err  out  1  level; the load failed.
- o_words  out  13  count of words written in the current load.

Behaviour:
- Reset (async, i_reset_n=0):
  - State goes to IDLE.
  - o_byte_ready, o_rom_we, o_done and o_err = 0; o_rom_w_addr = BASE_ADDR; o_rom_w_data = 0; o_words = 0.
  - o_cpu_hold = HOLD_AT_RESET.
  - Reset mid-load abandons the load immediately; words already written stay in the ROM.
- A byte is accepted only on a cycle with i_byte_valid && o_byte_ready.
- Bytes are little-endian: the first byte goes to [7:0], the fourth to [31:24].
- States:
  - IDLE: o_byte_ready=0. i_start moves to HDR, sets o_cpu_hold=1, clears o_done, o_err and o_words, and loads o_rom_w_addr=BASE_ADDR.
  - HDR: o_byte_ready=1. Collects 4 bytes into a 32-bit word count N. After the 4th byte:
    - N==0: go to DONE.
    - N>ROM_WORDS: go to ERR.
    - otherwise: go to DATA.
  - DATA: o_byte_ready=1. Collects 4 bytes into o_rom_w_data. After the 4th byte, go to WRITE on the next cycle.
  - WRITE: exactly one cycle.
    - o_rom_we=1 and o_byte_ready=0.
    - On exit: o_words increments and o_rom_w_addr increments by 4.
    - If o_words (after increment) == N, go to DONE (or CKSUM when enabled); otherwise go to DATA.
  - DONE: o_done=1, o_cpu_hold=0, o_byte_ready=0. Extra stream bytes are not accepted.
  - ERR: o_err=1, o_cpu_hold=1, o_byte_ready=0.
- i_start in DONE or ERR restarts the load exactly as from IDLE. i_start in HDR, DATA, WRITE or CKSUM is ignored.
- Timeout:
  - The idle counter resets on each accepted byte and on entry to HDR.
  - It counts cycles in HDR and DATA with no accepted byte.
  - When it reaches TIMEOUT_CYCLES, go to ERR.
- Latency: the 4th byte of a word is accepted in cycle t; o_rom_we=1 in cycle t+1. Peak rate is one word per 5 cycles.
- Address and count rules:
  - o_rom_w_addr never wraps; an image of N=ROM_WORDS ends at BASE_ADDR+4*(ROM_WORDS-1).
  - o_words holds up to 4096 (13 bits).

Optional Feature:
- Macro: ROM_LOADER_CKSUM_EN.
- Defined:
  - After the last WRITE, enter CKSUM and collect 4 more bytes (little-endian) as an expected sum.
  - Compare against the running sum, mod 2^32, of all written words.
  - Match goes to DONE; mismatch goes to ERR.
  - Timeout applies in CKSUM.
  - N==0 still collects the checksum and expects 0.
- Undefined: no CKSUM state and no trailer; behaviour is exactly as above.

Decomposition:
- Shared defines header gets:
  - state encodings: IDLE, HDR, DATA, WRITE, CKSUM, DONE, ERR (3 bits);
  - the ROM_WORDS default, tied to the existing ROM depth constant;
  - the ROMDataBus/ROMAddrBus widths, reused for port widths.
- One natural sub-module, rom_loader_word_asm: byte-lane shift register plus 2-bit lane counter, with word_valid output. The FSM, counters and timeout stay in the top module.

Test Plan:
- Load after reset: after reset o_cpu_hold=1. i_start, then bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00 -> ROM writes addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093; o_words=2; o_done=1, o_cpu_hold=0 the cycle after the 2nd write.
- Empty image: header 00 00 00 00 -> no o_rom_we pulse; DONE immediately after the 4th byte.
- Oversize header: header 01 10 00 00 (N=4097) -> ERR, o_err=1, o_cpu_hold=1, zero writes; a following i_start restarts cleanly.
- Stall and timeout: TIMEOUT_CYCLES=16; stop the stream after 2 data bytes -> ERR exactly 16 cycles after the last accepted byte. Gaps of 15 cycles -> load completes normally.
- Reset mid-load: assert i_reset_n=0 after 1 of 3 words written -> outputs go to reset values asynchronously; a new load of 3 words then writes addresses 0x0, 0x4 and 0x8.
- Checksum (ROM_LOADER_CKSUM_EN): words 0x00000013 and 0x00100093, trailer A6 00 10 00 -> DONE. Trailer A7 00 10 00 -> ERR with both writes already performed.
